// File: rtl/icache_ctrl_pkg.sv
// Shared widths, state encoding and address helpers for the instruction cache controller.
package icache_ctrl_pkg;

    localparam int ADDR_WIDTH        = 32;
    localparam int INS_WIDTH         = 32;
    localparam int ICACHE_INDEX_BITS = 6;
    localparam int ICACHE_TAG_WIDTH  = 14 - ICACHE_INDEX_BITS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Only addr[17:4] names a line; the upper address bits are always zero on the memctrl side.
    function automatic logic [31:0] refill_addr(input logic [13:0] line, input logic [1:0] word);
        refill_addr = {14'd0, line, word, 2'b00};
    endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped line storage: data words, tags and valid bits.
// Synchronous write port, combinational read port, synchronous valid clear.
module icache_array
    import icache_ctrl_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int TAG_W      = 14 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  i_clr,
    input  logic                  i_we,
    input  logic [INDEX_BITS-1:0] i_wr_index,
    input  logic [1:0]            i_wr_offset,
    input  logic [31:0]           i_wr_data,
    input  logic                  i_set_valid,
    input  logic [TAG_W-1:0]      i_set_tag,
    input  logic [INDEX_BITS-1:0] i_rd_index,
    input  logic [1:0]            i_rd_offset,
    output logic [31:0]           o_rd_data,
    output logic [TAG_W-1:0]      o_rd_tag,
    output logic                  o_rd_valid
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [31:0]      r_data [LINES*4];
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [LINES-1:0] r_valid;

    // Word and tag storage writes
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_data[{i_wr_index, i_wr_offset}] <= i_wr_data;
        end
        if (i_set_valid) begin
            r_tag[i_wr_index] <= i_set_tag;
        end
    end

    // Valid bits; a clear wins over a same-cycle line validation
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_valid <= '0;
        end else if (i_set_valid) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    assign o_rd_data  = r_data[{i_rd_index, i_rd_offset}];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_valid = r_valid[i_rd_index];

endmodule

// File: rtl/icache_ctrl.sv
// Blocking direct-mapped instruction cache between the fetcher and the memory controller.
// Misses refill the whole line word by word from word 0; a mispredict during refill drops the response.
module icache_ctrl
    import icache_ctrl_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        enable_from_if,
    input  logic [31:0] addr_from_if,
    output logic        ok_to_if,
    output logic [31:0] ins_to_if,
    output logic        enable_to_memctrl,
    output logic [31:0] addr_to_memctrl,
    input  logic        ok_from_memctrl,
    input  logic [31:0] ins_from_memctrl,
    input  logic        mispredict
);

    localparam int TAG_W = 14 - INDEX_BITS;

    state_t                r_state, w_state_nxt;
    logic [1:0]            r_cnt, w_cnt_nxt;
    logic                  r_cancel, w_cancel_nxt;
    logic [INDEX_BITS-1:0] r_index, w_index_nxt;
    logic [TAG_W-1:0]      r_tag, w_tag_nxt;
    logic [1:0]            r_offset, w_offset_nxt;
    logic                  r_ok, w_ok_nxt;
    logic [31:0]           r_ins, w_ins_nxt;
    logic                  r_en, w_en_nxt;
    logic [31:0]           r_addr, w_addr_nxt;

    logic [TAG_W-1:0]      w_req_tag;
    logic [INDEX_BITS-1:0] w_req_index;
    logic [1:0]            w_req_offset;
    logic [INDEX_BITS-1:0] w_rd_index;
    logic [1:0]            w_rd_offset;
    logic [31:0]           w_rd_data;
    logic [TAG_W-1:0]      w_rd_tag;
    logic                  w_rd_valid;
    logic                  w_hit;
    logic                  w_last;
    logic                  w_mem_take;
    logic                  w_unused;

    assign w_req_tag    = addr_from_if[17:4+INDEX_BITS];
    assign w_req_index  = addr_from_if[3+INDEX_BITS:4];
    assign w_req_offset = addr_from_if[3:2];
    assign w_unused     = ^{addr_from_if[31:18], addr_from_if[1:0]};

    // During refill the read port serves the pending offset so the last word can be returned.
    assign w_rd_index  = (r_state == ST_REFILL) ? r_index  : w_req_index;
    assign w_rd_offset = (r_state == ST_REFILL) ? r_offset : w_req_offset;
    assign w_hit       = w_rd_valid && (w_rd_tag == w_req_tag);
    assign w_last      = (r_cnt == 2'(LINE_WORDS - 1));
    assign w_mem_take  = (r_state == ST_REFILL) && r_en && ok_from_memctrl && rdy;

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk         (clk),
        .i_clr       (rst),
        .i_we        (w_mem_take),
        .i_wr_index  (r_index),
        .i_wr_offset (r_cnt),
        .i_wr_data   (ins_from_memctrl),
        .i_set_valid (w_mem_take && w_last),
        .i_set_tag   (r_tag),
        .i_rd_index  (w_rd_index),
        .i_rd_offset (w_rd_offset),
        .o_rd_data   (w_rd_data),
        .o_rd_tag    (w_rd_tag),
        .o_rd_valid  (w_rd_valid)
    );

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_cancel_nxt = r_cancel;
        w_index_nxt  = r_index;
        w_tag_nxt    = r_tag;
        w_offset_nxt = r_offset;
        w_ok_nxt     = 1'b0;
        w_ins_nxt    = r_ins;
        w_en_nxt     = 1'b0;
        w_addr_nxt   = r_addr;
        case (r_state)
            ST_IDLE: begin
                if (enable_from_if && !mispredict) begin
                    if (w_hit) begin
                        w_state_nxt = ST_RESP;
                        w_ok_nxt    = 1'b1;
                        w_ins_nxt   = w_rd_data;
                    end else begin
                        w_state_nxt  = ST_REFILL;
                        w_index_nxt  = w_req_index;
                        w_tag_nxt    = w_req_tag;
                        w_offset_nxt = w_req_offset;
                        w_cnt_nxt    = 2'd0;
                        w_cancel_nxt = 1'b0;
                        w_en_nxt     = 1'b1;
                        w_addr_nxt   = refill_addr({w_req_tag, w_req_index}, 2'd0);
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REFILL: begin
                w_cancel_nxt = r_cancel | mispredict;
                if (w_mem_take) begin
                    w_cnt_nxt = r_cnt + 2'd1;
                    if (w_last) begin
                        w_cancel_nxt = 1'b0;
                        if (r_cancel || mispredict) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_RESP;
                            w_ok_nxt    = 1'b1;
                            w_ins_nxt   = (r_offset == r_cnt) ? ins_from_memctrl : w_rd_data;
                        end
                    end else begin
                        w_state_nxt = ST_REFILL;
                    end
                end else if (!r_en) begin
                    // One idle cycle after each returned word, then request the next one.
                    w_en_nxt   = 1'b1;
                    w_addr_nxt = refill_addr({r_tag, r_index}, r_cnt);
                end else begin
                    w_en_nxt = 1'b1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset outranks the rdy freeze
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 2'd0;
            r_cancel <= 1'b0;
            r_index  <= '0;
            r_tag    <= '0;
            r_offset <= 2'd0;
            r_ok     <= 1'b0;
            r_ins    <= 32'd0;
            r_en     <= 1'b0;
            r_addr   <= 32'd0;
        end else if (rdy) begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_cancel <= w_cancel_nxt;
            r_index  <= w_index_nxt;
            r_tag    <= w_tag_nxt;
            r_offset <= w_offset_nxt;
            r_ok     <= w_ok_nxt;
            r_ins    <= w_ins_nxt;
            r_en     <= w_en_nxt;
            r_addr   <= w_addr_nxt;
        end
    end

    assign ok_to_if          = r_ok;
    assign ins_to_if         = r_ins;
    assign enable_to_memctrl = r_en;
    assign addr_to_memctrl   = r_addr;

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: the bench plays fetcher and memory controller and
// predicts hits, refill addresses and returned words from a line-level cache model.
module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        enable_from_if = 1'b0;
    logic [31:0] addr_from_if = 32'd0;
    logic        mispredict = 1'b0;
    logic        ok_from_memctrl = 1'b0;
    logic [31:0] ins_from_memctrl = 32'd0;
    logic        ok_to_if;
    logic [31:0] ins_to_if;
    logic        enable_to_memctrl;
    logic [31:0] addr_to_memctrl;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    icache_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .enable_from_if    (enable_from_if),
        .addr_from_if      (addr_from_if),
        .ok_to_if          (ok_to_if),
        .ins_to_if         (ins_to_if),
        .enable_to_memctrl (enable_to_memctrl),
        .addr_to_memctrl   (addr_to_memctrl),
        .ok_from_memctrl   (ok_from_memctrl),
        .ins_from_memctrl  (ins_from_memctrl),
        .mispredict        (mispredict)
    );

    // Line-level model: valid/tag per index, expected memctrl reads and fetch results
    logic        m_valid [64];
    logic [7:0]  m_tag   [64];
    logic [31:0] exp_ins_q [$];
    logic [31:0] exp_rd_q  [$];
    logic [31:0] rd_log    [$];
    int          ok_count = 0;
    int          served   = 0;
    logic [31:0] last_ins = 32'd0;

    logic        busy = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] lat_addr = 32'd0;
    logic        prev_rdy = 1'b1;
    logic        prev_en = 1'b0;
    logic        prev_ok = 1'b0;
    logic [31:0] prev_addr = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] m;
        m = a & 32'h0003_FFFC;
        return (((m >> 2) & 32'd3) + 32'd1) * 32'h11 + ((m >> 4) << 8);
    endfunction

    function automatic logic [31:0] rd_at(input int i);
        return (rd_log.size() > i) ? rd_log[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Compare process and memory-controller responder, sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            busy = 1'b0;
            ok_from_memctrl = 1'b0;
        end else begin
            if (!rdy && !prev_rdy) begin
                check("freeze_en", 32'(enable_to_memctrl), 32'(prev_en));
                check("freeze_addr", addr_to_memctrl, prev_addr);
                check("freeze_ok", 32'(ok_to_if), 32'(prev_ok));
            end
            if (rdy) begin
                if (ok_to_if) begin
                    if (exp_ins_q.size() == 0) fail_now("unexpected_ok_to_if");
                    else check("ins_to_if", ins_to_if, exp_ins_q.pop_front());
                    ok_count++;
                    last_ins = ins_to_if;
                end
                if (ok_from_memctrl) begin
                    check("en_gap_after_ok", 32'(enable_to_memctrl), 32'd0);
                    ok_from_memctrl = 1'b0;
                    busy = 1'b0;
                    served++;
                end else if (busy) begin
                    if (wait_cnt == 0) begin
                        ok_from_memctrl  = 1'b1;
                        ins_from_memctrl = mem_word(lat_addr);
                    end else begin
                        wait_cnt--;
                    end
                end else if (enable_to_memctrl) begin
                    busy = 1'b1;
                    wait_cnt = 1;
                    lat_addr = addr_to_memctrl;
                    rd_log.push_back(addr_to_memctrl);
                    if (exp_rd_q.size() == 0) fail_now("unexpected_memctrl_read");
                    else check("memctrl_addr", addr_to_memctrl, exp_rd_q.pop_front());
                end
            end
        end
        prev_rdy  = rdy;
        prev_en   = enable_to_memctrl;
        prev_ok   = ok_to_if;
        prev_addr = addr_to_memctrl;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic predict(input logic [31:0] a, input bit deliver, output bit hit);
        logic [31:0] m;
        int idx;
        int tg;
        m   = a & 32'h0003_FFFC;
        idx = int'((m >> 4) % 64);
        tg  = int'((m >> 10) % 256);
        hit = m_valid[idx] && (m_tag[idx] == 8'(tg));
        if (!hit) begin
            for (int i = 0; i < 4; i++) exp_rd_q.push_back((m & 32'h0003_FFF0) + 32'(4 * i));
            m_valid[idx] = 1'b1;
            m_tag[idx]   = 8'(tg);
        end
        if (deliver) exp_ins_q.push_back(mem_word(m));
    endtask

    task automatic fetch(input logic [31:0] a, input int stall_after, output logic [31:0] got);
        bit hit;
        int lat = 0;
        int c0 = ok_count;
        int s0 = served;
        bit stalled = 1'b0;
        predict(a, 1'b1, hit);
        enable_from_if = 1'b1;
        addr_from_if   = a;
        while (ok_count == c0 && lat < 300) begin
            tick();
            lat++;
            if (stall_after >= 0 && !stalled && served == s0 + stall_after && ok_count == c0) begin
                stalled = 1'b1;
                rdy = 1'b0;
                repeat (5) tick();
                rdy = 1'b1;
            end
        end
        enable_from_if = 1'b0;
        got = last_ins;
        if (ok_count == c0) fail_now("fetch_timeout");
        else if (hit) check("hit_latency", 32'(lat), 32'd1);
        else begin
            n_tests++;
            if (lat <= 1) begin
                n_fail++;
                $display("FAIL miss_latency: got %0d, want more than 1", lat);
            end
        end
        tick();
    endtask

    task automatic wait_served(input int target);
        int t = 0;
        while (served < target && t < 300) begin
            tick();
            t++;
        end
        if (served < target) fail_now("refill_timeout");
    endtask

    logic [31:0] got;
    int c0;
    int s0;
    bit hit;

    initial begin
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 8'd0;
        end
        repeat (3) tick();
        rst = 1'b0;
        check("reset_ok_to_if", 32'(ok_to_if), 32'd0);
        check("reset_ins_to_if", ins_to_if, 32'd0);
        check("reset_enable_mem", 32'(enable_to_memctrl), 32'd0);
        check("reset_addr_mem", addr_to_memctrl, 32'd0);
        tick();

        // Cold miss
        fetch(32'h0000_0008, -1, got);
        check("cold_miss_word", got, 32'h0000_0033);
        check("cold_rd0", rd_at(0), 32'h0000_0000);
        check("cold_rd1", rd_at(1), 32'h0000_0004);
        check("cold_rd2", rd_at(2), 32'h0000_0008);
        check("cold_rd3", rd_at(3), 32'h0000_000C);

        // Hits, including ignored upper and low address bits
        fetch(32'h0000_000C, -1, got);
        check("hit_word", got, 32'h0000_0044);
        check("hit_no_reads", 32'(rd_log.size()), 32'd4);
        fetch(32'hFFFC_000B, -1, got);
        check("hit_ignored_bits", got, 32'h0000_0033);

        // Conflict on index 0
        fetch(32'h0000_0400, -1, got);
        check("conflict_word", got, 32'h0000_4011);
        check("conflict_rd0", rd_at(4), 32'h0000_0400);
        check("conflict_rd3", rd_at(7), 32'h0000_040C);
        fetch(32'h0000_0000, -1, got);
        check("evicted_word", got, 32'h0000_0011);
        check("evicted_rd0", rd_at(8), 32'h0000_0000);

        // Mispredict in IDLE ignores the request
        c0 = ok_count;
        s0 = served;
        enable_from_if = 1'b1;
        addr_from_if   = 32'h0000_0800;
        mispredict     = 1'b1;
        tick();
        enable_from_if = 1'b0;
        mispredict     = 1'b0;
        repeat (6) tick();
        check("idle_mispredict_no_ok", 32'(ok_count - c0), 32'd0);
        check("idle_mispredict_no_read", 32'(served - s0), 32'd0);

        // Mispredict during the second word: refill completes, no response
        c0 = ok_count;
        s0 = served;
        predict(32'h0000_1234, 1'b0, hit);
        enable_from_if = 1'b1;
        addr_from_if   = 32'h0000_1234;
        wait_served(s0 + 1);
        tick();
        mispredict     = 1'b1;
        enable_from_if = 1'b0;
        tick();
        mispredict = 1'b0;
        wait_served(s0 + 4);
        repeat (4) tick();
        check("cancel_words_served", 32'(served - s0), 32'd4);
        check("cancel_no_ok", 32'(ok_count - c0), 32'd0);
        fetch(32'h0000_1238, -1, got);
        check("after_cancel_hit_word", got, 32'h0001_2333);

        // rdy low for 5 cycles in the middle of a refill
        fetch(32'h0000_2004, 1, got);
        check("stall_word", got, 32'h0002_0022);

        // Reset mid-refill abandons the line
        s0 = served;
        predict(32'h0000_3008, 1'b1, hit);
        enable_from_if = 1'b1;
        addr_from_if   = 32'h0000_3008;
        wait_served(s0 + 1);
        rst = 1'b1;
        enable_from_if = 1'b0;
        exp_rd_q.delete();
        exp_ins_q.delete();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        check("midreset_enable_mem", 32'(enable_to_memctrl), 32'd0);
        check("midreset_addr_mem", addr_to_memctrl, 32'd0);
        check("midreset_ok", 32'(ok_to_if), 32'd0);
        tick();
        fetch(32'h0000_3008, -1, got);
        check("after_reset_word", got, 32'h0003_0033);
        check("after_reset_rd0", rd_at(rd_log.size() - 4), 32'h0000_3000);
        fetch(32'h0000_0008, -1, got);
        check("after_reset_cold_line", got, 32'h0000_0033);

        repeat (4) tick();
        check("pending_reads_left", 32'(exp_rd_q.size()), 32'd0);
        check("pending_responses_left", 32'(exp_ins_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameter INDEX_BITS, default 6, SHALL set the number of cache lines to 2^INDEX_BITS.
REQ-002 Parameter LINE_WORDS, default 4, SHALL set the 32-bit words per line; it is fixed at 4 and the offset is addr[3:2].
REQ-003 clk  input  1  system clock; one clock domain only.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rdy  input  1  when low, all state and outputs SHALL freeze.
REQ-006 enable_from_if  input  1  fetch request, level-held by the fetcher until ok_to_if.
REQ-007 addr_from_if  input  32  fetch PC; bits [1:0] are ignored and bits [31:18] are ignored.
REQ-008 ok_to_if  output  1  one-cycle pulse: ins_to_if is valid.
REQ-009 ins_to_if  output  32  fetched instruction word.
REQ-010 enable_to_memctrl  output  1  word-read request, held until ok_from_memctrl.
REQ-011 addr_to_memctrl  output  32  word-aligned refill address.
REQ-012 ok_from_memctrl  input  1  one-cycle pulse: the refill word is valid.
REQ-013 ins_from_memctrl  input  32  refill word.
REQ-014 mispredict  input  1  flush; cancels any pending response.

Function
REQ-015 The address SHALL split as follows: tag = addr[17:4+INDEX_BITS], index = addr[3+INDEX_BITS:4], offset = addr[3:2]. With the default parameter the tag is 8 bits.
REQ-016 The cache SHALL be direct-mapped, with one valid bit per line.
REQ-017 The FSM states SHALL be IDLE, REFILL and RESP.
REQ-018 In IDLE with enable_from_if=1, mispredict=0 and a hit, the block SHALL latch the word and go to RESP. ok_to_if SHALL pulse in the next cycle (hit latency 1).
REQ-019 In IDLE with enable_from_if=1, mispredict=0 and a miss, the block SHALL record the index and tag, set word counter=0 and go to REFILL.
REQ-020 In REFILL, the block SHALL drive enable_to_memctrl=1 and addr_to_memctrl={14'b0, tag, index, counter, 2'b00}.
REQ-021 On ok_from_memctrl, the block SHALL write ins_from_memctrl into word[counter] and increment the 2-bit counter. enable_to_memctrl SHALL drop for exactly one cycle after each ok before the next word is requested.
REQ-022 On the ok for word 3, the block SHALL set the line's valid bit and the tag, and go to RESP. ins_to_if SHALL be the word at the requested offset.
REQ-023 The refill SHALL always start at word 0 and SHALL fill all 4 words; no critical-word-first.
REQ-024 RESP SHALL last one cycle, with ok_to_if=1, then return to IDLE. Requests are not sampled in RESP, so hit throughput is one instruction per 2 cycles.
REQ-025 mispredict in IDLE SHALL cause the request to be ignored that cycle.
REQ-026 mispredict in REFILL SHALL set a cancel flag. The refill SHALL still complete and validate the line, and RESP SHALL be skipped (REFILL -> IDLE, no ok_to_if).
REQ-027 mispredict in RESP SHALL NOT suppress ok_to_if; the fetcher discards that word.
REQ-028 Refill writes SHALL only target the recorded index, so there are no simultaneous read and write conflicts.
REQ-029 A hit lookup SHALL NOT occur during REFILL.
REQ-030 Outside REFILL, enable_to_memctrl SHALL be 0 and addr_to_memctrl SHALL hold its last value.
REQ-031 ok_from_memctrl arriving outside REFILL SHALL be ignored.

Reset
REQ-032 On rst=1 at a clock edge, the block SHALL clear all valid bits, set state=IDLE, counter=0, cancel=0, ok_to_if=0, ins_to_if=0, enable_to_memctrl=0 and addr_to_memctrl=0.
REQ-033 Reset mid-refill SHALL abandon the line, which stays invalid.
REQ-034 rst SHALL take priority over rdy.

Structure
REQ-035 ADDR_WIDTH, INS_WIDTH, ICACHE_INDEX_BITS, ICACHE_TAG_WIDTH and the state encodings SHALL reside in the shared define.v.
REQ-036 The storage (data, tag, valid) SHALL be one sub-module, icache_array. It has a synchronous write port, a combinational read port, and a synchronous valid clear.
REQ-037 The instance sits between InsFetcher and Memctrl. The Memctrl IF port semantics are unchanged.

Verification
REQ-038 Cold miss: after reset, request 0x00000008. The bench SHALL see memctrl reads at 0x0, 0x4, 0x8 and 0xC, returning 0x11, 0x22, 0x33 and 0x44. It SHALL then see exactly one ok_to_if, with ins_to_if=0x33.
REQ-039 Hit: then request 0x0000000C. The bench SHALL see ok_to_if one cycle later with ins_to_if=0x44, and enable_to_memctrl SHALL never rise.
REQ-040 Conflict: request 0x00000400, same index 0 with tag 1. The bench SHALL see a refill from 0x400..0x40C. A following request to 0x0 SHALL miss again.
REQ-041 Mispredict mid-refill: assert mispredict during the 2nd word. The refill SHALL complete and ok_to_if SHALL stay 0. A following request to the same line SHALL hit with 1-cycle latency.
REQ-042 rdy low for 5 cycles during REFILL: the counter, address and state SHALL be held, and the result SHALL be identical to the uninterrupted run.
REQ-043 Reset mid-refill: the next request to the same address SHALL miss and refill from word 0.
